// File: rtl/dnn_accuracy_monitor.sv
// dnn_accuracy_monitor: on-chip accuracy bookkeeping for the DNN top.
// Each block cycle it collects the serial ideal outputs, snapshots the
// thresholded network outputs, and scores the case one clock later. It
// tracks sliding-window accuracy, running totals, the training-case select
// and epoch count.
module dnn_accuracy_monitor #(
    parameter int n_out          = 16,
    parameter int ypc            = 1,
    parameter int cpc            = 18,
    parameter int checklast      = 1000,
    parameter int training_cases = 10000,
    parameter int total_cases    = 100000
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           en,
    input  logic [$clog2(cpc)-1:0]         cycle_index,
    input  logic [ypc-1:0]                 y_out,
    input  logic [n_out-1:0]               a_out_alln,
    output logic                           case_done,
    output logic                           correct,
    output logic [$clog2(checklast+1)-1:0] recent,
    output logic [31:0]                    total_correct,
    output logic [31:0]                    num_train,
    output logic [$clog2(training_cases)-1:0] sel_tc,
    output logic [15:0]                    epoch,
    output logic                           epoch_done,
    output logic                           finished
);

    localparam int CIW    = $clog2(cpc);
    localparam int RW     = $clog2(checklast + 1);
    localparam int SW     = $clog2(training_cases);
    localparam int PW     = (checklast > 1) ? $clog2(checklast) : 1;
    localparam int CHUNKS = n_out / ypc;

    logic [n_out-1:0]     y_vec_q, y_vec_d;
    logic [n_out-1:0]     a_snap_q, a_snap_d;
    logic                 pend_q, pend_d;
    logic [checklast-1:0] win_q, win_d;
    logic [PW-1:0]        ptr_q, ptr_d;
    logic                 case_done_q, case_done_d;
    logic                 correct_q, correct_d;
    logic [RW-1:0]        recent_q, recent_d;
    logic [31:0]          total_correct_q, total_correct_d;
    logic [31:0]          num_train_q, num_train_d;
    logic [SW-1:0]        sel_tc_q, sel_tc_d;
    logic [15:0]          epoch_q, epoch_d;
    logic                 epoch_done_q, epoch_done_d;
    logic                 finished_q, finished_d;

    logic                 is_snap;
    logic                 match;
    logic                 sel_wrap;

    assign is_snap  = (cycle_index == CIW'(cpc - 1));
    assign match    = (a_snap_q == y_vec_q);
    assign sel_wrap = (sel_tc_q == SW'(training_cases - 1));

    // Capture the ideal-output chunks, snapshot at the last block clock, then score on the next edge.
    always_comb begin
        y_vec_d         = y_vec_q;
        a_snap_d        = a_snap_q;
        pend_d          = pend_q;
        win_d           = win_q;
        ptr_d           = ptr_q;
        case_done_d     = 1'b0;
        correct_d       = correct_q;
        recent_d        = recent_q;
        total_correct_d = total_correct_q;
        num_train_d     = num_train_q;
        sel_tc_d        = sel_tc_q;
        epoch_d         = epoch_q;
        epoch_done_d    = 1'b0;
        finished_d      = finished_q;

        for (int i = 0; i < CHUNKS; i++) begin
            if (cycle_index == CIW'(i + 2)) begin
                y_vec_d[i*ypc +: ypc] = y_out;
            end
        end

        if (is_snap) begin
            a_snap_d = a_out_alln;
            pend_d   = en & ~finished_q;
        end else if (pend_q) begin
            pend_d          = 1'b0;
            case_done_d     = 1'b1;
            correct_d       = match;
            recent_d        = recent_q - RW'(win_q[ptr_q]) + RW'(match);
            win_d[ptr_q]    = match;
            ptr_d           = (ptr_q == PW'(checklast - 1)) ? '0 : ptr_q + 1'b1;
            total_correct_d = total_correct_q + 32'(match);
            num_train_d     = num_train_q + 32'd1;
            sel_tc_d        = sel_wrap ? '0 : sel_tc_q + 1'b1;
            if (sel_wrap) begin
                epoch_d      = epoch_q + 16'd1;
                epoch_done_d = 1'b1;
            end
            if (num_train_q + 32'd1 == 32'(total_cases)) begin
                finished_d = 1'b1;
            end
        end
    end

    // State registers; reset discards any partial case and clears the window.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            y_vec_q         <= '0;
            a_snap_q        <= '0;
            pend_q          <= 1'b0;
            win_q           <= '0;
            ptr_q           <= '0;
            case_done_q     <= 1'b0;
            correct_q       <= 1'b0;
            recent_q        <= '0;
            total_correct_q <= '0;
            num_train_q     <= '0;
            sel_tc_q        <= '0;
            epoch_q         <= '0;
            epoch_done_q    <= 1'b0;
            finished_q      <= 1'b0;
        end else begin
            y_vec_q         <= y_vec_d;
            a_snap_q        <= a_snap_d;
            pend_q          <= pend_d;
            win_q           <= win_d;
            ptr_q           <= ptr_d;
            case_done_q     <= case_done_d;
            correct_q       <= correct_d;
            recent_q        <= recent_d;
            total_correct_q <= total_correct_d;
            num_train_q     <= num_train_d;
            sel_tc_q        <= sel_tc_d;
            epoch_q         <= epoch_d;
            epoch_done_q    <= epoch_done_d;
            finished_q      <= finished_d;
        end
    end

    assign case_done     = case_done_q;
    assign correct       = correct_q;
    assign recent        = recent_q;
    assign total_correct = total_correct_q;
    assign num_train     = num_train_q;
    assign sel_tc        = sel_tc_q;
    assign epoch         = epoch_q;
    assign epoch_done    = epoch_done_q;
    assign finished      = finished_q;

endmodule

// File: tb/tb_dnn_accuracy_monitor.sv
// tb_dnn_accuracy_monitor: scoreboard bench for dnn_accuracy_monitor with a
// small window (4), short epochs (3) and an early finish (7 cases).
module tb_dnn_accuracy_monitor;

    localparam int N_OUT = 16;
    localparam int CPC   = 18;
    localparam int CL    = 4;
    localparam int TC    = 3;
    localparam int TOT   = 7;

    logic        clk;
    logic        reset;
    logic        en;
    logic [4:0]  cycle_index;
    logic [0:0]  y_out;
    logic [15:0] a_out_alln;
    logic        case_done;
    logic        correct;
    logic [2:0]  recent;
    logic [31:0] total_correct;
    logic [31:0] num_train;
    logic [1:0]  sel_tc;
    logic [15:0] epoch;
    logic        epoch_done;
    logic        finished;

    typedef struct {
        logic correct;
        int   recent;
        int   total;
        int   num;
        int   sel;
        int   epoch;
        logic edone;
        logic fin;
    } exp_t;

    exp_t sb_q[$];

    int   check_count = 0;
    int   fail_count  = 0;

    int   m_recent, m_ptr, m_total, m_num, m_sel, m_epoch;
    logic m_fin;
    logic m_win [CL];

    logic last_correct;
    int   last_num;

    dnn_accuracy_monitor #(
        .n_out(N_OUT), .ypc(1), .cpc(CPC), .checklast(CL),
        .training_cases(TC), .total_cases(TOT)
    ) dut (
        .clk(clk), .reset(reset), .en(en), .cycle_index(cycle_index),
        .y_out(y_out), .a_out_alln(a_out_alln), .case_done(case_done),
        .correct(correct), .recent(recent), .total_correct(total_correct),
        .num_train(num_train), .sel_tc(sel_tc), .epoch(epoch),
        .epoch_done(epoch_done), .finished(finished)
    );

    // Free-running clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Count a comparison and report it when observed and expected differ.
    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        check_count++;
        if (got !== exp) begin
            fail_count++;
            $display("[TB] FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Drive one clock of inputs and step past the rising edge.
    task automatic driveStep(input int idx, input logic ybit, input logic [15:0] a, input logic e);
        cycle_index = 5'(idx);
        y_out       = ybit;
        a_out_alln  = a;
        en          = e;
        @(posedge clk);
        #1;
    endtask

    // Drive a block cycle up to stop_at; a full block (stop_at = CPC-1) is pushed to the model if it will be scored.
    task automatic applyStimulus(input logic [15:0] y, input logic [15:0] a,
                                 input logic en_snap, input logic en_rest, input int stop_at);
        logic match;
        exp_t e;
        for (int k = 0; k <= stop_at; k++) begin
            if (k == CPC - 1)
                driveStep(k, y[k-2], a, en_snap);
            else if (k >= 2)
                driveStep(k, y[k-2], 16'($urandom), en_rest);
            else
                driveStep(k, 1'($urandom), 16'($urandom), en_rest);
        end
        if (stop_at == CPC - 1 && en_snap && !m_fin) begin
            match      = (a == y);
            m_recent   = m_recent - int'(m_win[m_ptr]) + int'(match);
            m_win[m_ptr] = match;
            m_ptr      = (m_ptr == CL - 1) ? 0 : m_ptr + 1;
            m_total    = m_total + int'(match);
            m_num      = m_num + 1;
            e.edone    = (m_sel == TC - 1);
            m_sel      = e.edone ? 0 : m_sel + 1;
            if (e.edone) m_epoch = m_epoch + 1;
            if (m_num == TOT) m_fin = 1'b1;
            e.correct  = match;
            e.recent   = m_recent;
            e.total    = m_total;
            e.num      = m_num;
            e.sel      = m_sel;
            e.epoch    = m_epoch;
            e.fin      = m_fin;
            sb_q.push_back(e);
        end
    endtask

    // Let the last case be scored and observed, then confirm nothing is left pending.
    task automatic idleTail(input string tag);
        driveStep(0, 1'b0, 16'h0, 1'b0);
        driveStep(1, 1'b0, 16'h0, 1'b0);
        checkOutput(tag, sb_q.size(), 0);
    endtask

    // Assert reset between edges, confirm outputs clear at once, and clear the model.
    task automatic doReset(input string tag);
        reset = 1'b1;
        #2;
        checkOutput({tag, "_case_done"}, 32'(case_done), 0);
        checkOutput({tag, "_correct"}, 32'(correct), 0);
        checkOutput({tag, "_recent"}, 32'(recent), 0);
        checkOutput({tag, "_total"}, total_correct, 0);
        checkOutput({tag, "_num"}, num_train, 0);
        checkOutput({tag, "_sel_tc"}, 32'(sel_tc), 0);
        checkOutput({tag, "_epoch"}, 32'(epoch), 0);
        checkOutput({tag, "_epoch_done"}, 32'(epoch_done), 0);
        checkOutput({tag, "_finished"}, 32'(finished), 0);
        sb_q.delete();
        m_recent = 0; m_ptr = 0; m_total = 0; m_num = 0; m_sel = 0; m_epoch = 0; m_fin = 1'b0;
        for (int i = 0; i < CL; i++) m_win[i] = 1'b0;
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    // Scoreboard: compare each scored case against the model and check that idle clocks hold state.
    always @(negedge clk) begin
        exp_t e;
        if (reset) begin
            last_correct = 1'b0;
            last_num     = 0;
        end else if (case_done) begin
            if (sb_q.size() == 0) begin
                checkOutput("spurious_case_done", 32'(case_done), 0);
            end else begin
                e = sb_q.pop_front();
                checkOutput("correct", 32'(correct), 32'(e.correct));
                checkOutput("recent", 32'(recent), 32'(e.recent));
                checkOutput("total_correct", total_correct, 32'(e.total));
                checkOutput("num_train", num_train, 32'(e.num));
                checkOutput("sel_tc", 32'(sel_tc), 32'(e.sel));
                checkOutput("epoch", 32'(epoch), 32'(e.epoch));
                checkOutput("epoch_done", 32'(epoch_done), 32'(e.edone));
                checkOutput("finished", 32'(finished), 32'(e.fin));
                last_correct = e.correct;
                last_num     = e.num;
            end
        end else begin
            checkOutput("idle_epoch_done", 32'(epoch_done), 0);
            checkOutput("hold_correct", 32'(correct), 32'(last_correct));
            checkOutput("hold_num_train", num_train, 32'(last_num));
        end
    end

    // Watchdog so the run always terminates.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] timeout");
    end

    // Test sequence.
    initial begin
        logic [15:0] y;
        reset       = 1'b1;
        en          = 1'b0;
        cycle_index = '0;
        y_out       = '0;
        a_out_alln  = '0;
        #1;
        doReset("rst0");

        $display("[TB] basic scoring and single-bit mismatch");
        applyStimulus(16'h0008, 16'h0008, 1'b1, 1'b1, CPC - 1);
        idleTail("basic_drain");
        checkOutput("basic_sel_tc", 32'(sel_tc), 1);
        checkOutput("basic_recent", 32'(recent), 1);
        applyStimulus(16'h0008, 16'h0009, 1'b1, 1'b1, CPC - 1);
        idleTail("mismatch_drain");
        checkOutput("mismatch_correct", 32'(correct), 0);
        checkOutput("mismatch_recent", 32'(recent), 1);
        checkOutput("mismatch_num", num_train, 2);

        $display("[TB] window wrap, epochs and finish");
        doReset("rst1");
        for (int c = 0; c < 8; c++) begin
            y = 16'($urandom);
            if (c < 4 || c >= 6)
                applyStimulus(y, y, 1'b1, 1'b1, CPC - 1);
            else
                applyStimulus(y, y ^ 16'(1 << c), 1'b1, 1'b1, CPC - 1);
        end
        idleTail("finish_drain");
        checkOutput("finish_sticky", 32'(finished), 1);
        checkOutput("finish_num", num_train, 7);
        checkOutput("finish_epoch", 32'(epoch), 2);

        $display("[TB] enable gating");
        doReset("rst2");
        applyStimulus(16'h1234, 16'h1234, 1'b1, 1'b1, CPC - 1);
        applyStimulus(16'h00F0, 16'h00F0, 1'b0, 1'b1, CPC - 1);
        applyStimulus(16'hA5A5, 16'hA5A5, 1'b1, 1'b0, CPC - 1);
        idleTail("gate_drain");
        checkOutput("gate_sel_tc", 32'(sel_tc), 2);
        checkOutput("gate_num", num_train, 2);
        for (int c = 0; c < 3; c++) begin
            y = 16'($urandom);
            applyStimulus(y, (c == 1) ? ~y : y, 1'b1, 1'b1, CPC - 1);
        end

        $display("[TB] async reset mid-case");
        applyStimulus(16'hFFFF, 16'hFFFF, 1'b1, 1'b1, 9);
        checkOutput("pre_reset_num", num_train, 5);
        doReset("rst_mid");
        applyStimulus(16'h0101, 16'h0101, 1'b1, 1'b1, CPC - 1);
        idleTail("post_reset_drain");
        checkOutput("post_reset_num", num_train, 1);
        checkOutput("post_reset_sel_tc", 32'(sel_tc), 1);

        $display("TB_RESULT checks=%0d failures=%0d", check_count, fail_count);
        $finish;
    end

endmodule

// File: doc/dnn_accuracy_monitor.md
# dnn_accuracy_monitor

Synthesizable downstream monitor for the DNN top. Each block cycle it collects the serial ideal-output stream `y_out` and the parallel thresholded output `a_out_alln`, and decides whether the training case was classified correctly. It keeps a sliding-window accuracy over the last `checklast` cases, a running total, case and epoch counters, and the training-case select `sel_tc` used by the upstream input feeder. This replaces the simulation-only accuracy bookkeeping so that accuracy can be read on hardware.

## Interface
- `n_out`, 16: number of output neurons. Equals n[L-1].
- `ypc`, 1: ideal-output bits per clock. Equals z[L-2]/fi[L-2]; `n_out` must be a multiple of `ypc`.
- `cpc`, 18: clocks per block cycle. Must equal `n_out/ypc + 2`.
- `checklast`, 1000: sliding-window depth in cases.
- `training_cases`, 10000: cases per epoch.
- `total_cases`, 100000: total cases before `finished` asserts.

Ports:
- `clk`, in, 1: the single clock; all state updates on its rising edge.
- `reset`, in, 1: asynchronous, active-high; clears all state.
- `en`, in, 1: when high, cases are counted. Sampled on the capture edge.
- `cycle_index`, in, $clog2(cpc): block-cycle position from the cycle_block_counter.
- `y_out`, in, ypc: ideal output bits from the DNN, valid while cycle_index is in 2..cpc-1.
- `a_out_alln`, in, n_out: thresholded network output, valid when cycle_index = cpc-1.
- `case_done`, out, 1: one-clock pulse when a case is scored.
- `correct`, out, 1: result of the last scored case.
- `recent`, out, $clog2(checklast+1): number of correct cases in the window.
- `total_correct`, out, 32: correct cases since reset.
- `num_train`, out, 32: cases scored since reset.
- `sel_tc`, out, $clog2(training_cases): index of the current training case.
- `epoch`, out, 16: completed epochs.
- `epoch_done`, out, 1: one-clock pulse, coincident with `case_done`, when `sel_tc` wraps.
- `finished`, out, 1: sticky; set when `num_train` reaches `total_cases`.

## Operation
- **Capture.** When cycle_index = k with 2 ≤ k ≤ cpc-1:
  - `y_vec[(k-2)*ypc +: ypc]` <= `y_out`.
  - For other values of cycle_index, `y_vec` holds.
- **Snapshot.** On the edge where cycle_index = cpc-1:
  - `a_snap` <= `a_out_alln`.
  - `pend` <= `en & ~finished`.
- **Score.** On the next edge (cycle_index = 0), if `pend` is set:
  - `match` = (`a_snap` == `y_vec`). All n_out bits must be equal.
  - `correct` <= `match`; `case_done` <= 1.
  - `recent` <= `recent - win[ptr] + match`; `win[ptr]` <= `match`.
  - `ptr` <= (`ptr` == checklast-1) ? 0 : `ptr`+1.
  - `total_correct` += `match`; `num_train` += 1.
  - `sel_tc` <= (`sel_tc` == training_cases-1) ? 0 : `sel_tc`+1.
  - If `sel_tc` wraps: `epoch` += 1 and `epoch_done` <= 1.
  - If `num_train`+1 == total_cases: `finished` <= 1.
  - `pend` <= 0.
- **Idle cases.** If `pend` is not set at the score edge, all counters, `win` and `ptr` hold, and `correct` holds its last value.
- **Window buffer.** `win` is a checklast×1 bit register array, cleared to 0 on reset. Until checklast cases have been scored, the missing entries count as 0, so `recent` equals the number of correct cases scored so far.
- **Counter widths.** `recent` never exceeds checklast, so it cannot overflow. The 32-bit counters wrap modulo 2^32, but this cannot happen before `finished`. `epoch` wraps modulo 2^16.

## Timing
- **Reset values.** While `reset` is high, every output and all internal state are 0: `y_vec`, `a_snap`, `pend`, `win`, `ptr`.
- **Latency.** Counter outputs and `case_done` change 1 clock after the snapshot edge. `case_done` is high for exactly 1 clock, during cycle_index = 1.
- **Reset mid-operation.** The partial case is discarded and nothing is scored. The first scoreable case after reset is the first block cycle that reaches cycle_index = cpc-1.
- **Simultaneous events.** Buffer wrap (`ptr` returning to 0), epoch wrap and `finished` can all occur on the same score edge; each takes effect independently.
- **Window replacement.** When `ptr` wraps, the bit being replaced is the case scored checklast cases earlier.
- **After `finished`.** `pend` never sets again, so all counters freeze until reset.
- **`en` dropped mid-case.** Only the value of `en` at the snapshot edge matters.

## Test plan
- **Basic scoring.** Reset, then `en`=1. Feed y bits = one-hot 0x0008 over cycles 2..17, and `a_out_alln`=0x0008 at cycle 17. Expect `case_done` at cycle_index 1 with `correct`=1, `recent`=1, `total_correct`=1, `num_train`=1, `sel_tc`=1.
- **Single-bit mismatch.** Same y as above, but `a_out_alln`=0x0009. Expect `correct`=0, `recent` unchanged, `num_train` incremented.
- **Window full.** Run with checklast=4: 4 correct cases, then 2 wrong. Expect `recent` sequence 1,2,3,4,3,2 and `ptr` wrapping to 0 after the 4th case.
- **Epoch and finish.** Use training_cases=3 and total_cases=7. Expect `epoch_done` pulses after cases 3 and 6, `epoch`=2, `finished`=1 after case 7, and an 8th case that changes nothing.
- **`en` gating.** Set `en`=0 at the snapshot edge of case 2. Expect no `case_done` for that block cycle and `sel_tc` unchanged.
- **Async reset mid-case.** Pulse `reset` at cycle_index 9 after 5 scored cases. Expect all outputs 0 immediately, with no clock edge needed, and the next full block cycle scored as case 1.
